// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state type for the round-robin grant encoder.
// Imported by the interface, the picker and the top level.
package rr_arb_pkg;
    localparam int ARB_N       = 8;
    localparam int ARB_IDXW    = 3;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arb_enc_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// The master drives en/req/done; the slave returns the registered grant view.
interface rr_arb_enc_if
    import rr_arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = ARB_IDXW
);
    logic            en;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;
    logic            to_pls;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_vld, to_pls
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_vld, to_pls
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating priority picker: first set req bit at or after ptr, wrapping mod N.
// Purely combinational; no backpressure (caller decides when to take win).
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = ARB_IDXW
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    win,
    output logic [IDXW-1:0] win_idx,
    output logic            any
);
    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;
    logic         found;

    always_comb begin
        rot     = '0;
        rot_oh  = '0;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        any     = |req;
        // rot[0] is the requester at ptr, so a plain LSB-first search is the round-robin order
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDXW'((i + int'(ptr)) % N)];
        end
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found     = 1'b1;
                rot_oh[i] = 1'b1;
                win_idx   = IDXW'((i + int'(ptr)) % N);
            end
        end
        for (int m = 0; m < N; m++) begin
            win[m] = rot_oh[IDXW'((m - int'(ptr) + N) % N)];
        end
    end
endmodule

// File: rtl/rr_arb_enc.sv
// Round-robin arbiter with one-hot + binary-index grant; ARB_TIMEOUT_EN adds a hold limit.
// Latency: req -> gnt 1 clock; releases regrant on the same edge (no bubble).
// Backpressure: en=0 blocks new grants; an active grant holds until done/withdrawal/timeout.
module rr_arb_enc
    import rr_arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = ARB_IDXW
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = ARB_TIMEOUT
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_enc_if.slave  bus
);
    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            vld_q, vld_d;
    logic            tmo;
    logic            rel;
    logic [IDXW-1:0] pick_ptr;
    logic [IDXW-1:0] idx_inc;
    logic [N-1:0]    win;
    logic [IDXW-1:0] win_idx;
    logic            any;

    assign idx_inc  = (int'(idx_q) == N - 1) ? '0 : idx_q + IDXW'(1);
    assign rel      = (state_q == GRANT) && (bus.done || !bus.req[idx_q] || tmo);
    // In GRANT the search already starts past the current owner so a release can regrant this edge
    assign pick_ptr = (state_q == GRANT) ? idx_inc : ptr_q;

    rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (bus.en && any) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d = idx_inc;
                    if (bus.en && any) begin
                        gnt_d = win;
                        idx_d = win_idx;
                        vld_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q;

    assign tmo = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT - 1));

    // Clearing on every release means any grant loaded on that edge starts from zero
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == IDLE || rel) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= rel && tmo;
        end
    end

    assign bus.to_pls = to_q;
`else
    assign tmo        = 1'b0;
    assign bus.to_pls = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
endmodule

// File: tb/tb_rr_arb_enc.sv
// Directed bench for rr_arb_enc: reset, grant latency, rotation, wrap, withdrawal/enable,
// idle done, and the timeout pulse when ARB_TIMEOUT_EN is defined.
module tb_rr_arb_enc;
    import rr_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rr_arb_enc_if bus ();

    rr_arb_enc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.to_pls} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: gnt=%h idx=%0d vld=%b to=%b, want all 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.to_pls);
        end
    endtask

    task automatic test_single();
        bus.en  = 1'b1;
        bus.req = 8'b0000_1000;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h08, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL single_grant: gnt=%h idx=%0d vld=%b, want 08 3 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h08, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL single_hold: gnt=%h idx=%0d vld=%b, want 08 3 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tests++;
        // req[3] still asserted: releaser is lowest priority but still the only requester
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h08, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL single_regrant: gnt=%h idx=%0d vld=%b, want 08 3 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        bus.req = 8'h00;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== 12'h0) begin
            fails++;
            $display("FAIL single_idle: gnt=%h idx=%0d vld=%b, want 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
    endtask

    task automatic test_reset_mid_grant();
        // ptr is now 4; requester 3 is found after wrapping
        bus.req = 8'b0000_1000;
        tick();
        tests++;
        if (bus.gnt_idx !== 3'd3 || bus.gnt_vld !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_grant: idx=%0d vld=%b, want 3 1", bus.gnt_idx, bus.gnt_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== 12'h0) begin
            fails++;
            $display("FAIL async_reset: gnt=%h idx=%0d vld=%b, want 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        bus.req = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h01, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_ptr0: gnt=%h idx=%0d vld=%b, want 01 0 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_gnt;
        logic [2:0] exp_idx;
        int         bad;
        bad      = 0;
        bus.done = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_idx = 3'(k % 8);
            exp_gnt = 8'h01 << exp_idx;
            tests++;
            if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {exp_gnt, exp_idx, 1'b1}) begin
                fails++;
                $display("FAIL rotation_%0d: gnt=%h idx=%0d vld=%b, want %h %0d 1",
                         k, bus.gnt, bus.gnt_idx, bus.gnt_vld, exp_gnt, exp_idx);
            end
        end
        bus.done = 1'b0;
    endtask

    task automatic test_wrap();
        // Drop requester 0 so the search from ptr 1 lands on 7
        bus.req = 8'h80;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h80, 3'd7}) begin
            fails++;
            $display("FAIL wrap_setup: gnt=%h idx=%0d, want 80 7", bus.gnt, bus.gnt_idx);
        end
        bus.req  = 8'b1000_0001;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h01, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL wrap_fair: gnt=%h idx=%0d vld=%b, want 01 0 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
    endtask

    task automatic test_withdraw_enable();
        bus.req = 8'h04;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h04, 3'd2}) begin
            fails++;
            $display("FAIL withdraw_setup: gnt=%h idx=%0d, want 04 2", bus.gnt, bus.gnt_idx);
        end
        bus.en  = 1'b0;
        bus.req = 8'h10;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== 12'h0) begin
            fails++;
            $display("FAIL withdraw_idle: gnt=%h idx=%0d vld=%b, want 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        tick();
        tick();
        tests++;
        if (bus.gnt_vld !== 1'b0 || bus.gnt !== 8'h00) begin
            fails++;
            $display("FAIL en_blocks: gnt=%h vld=%b, want 00 0", bus.gnt, bus.gnt_vld);
        end
        bus.en = 1'b1;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {8'h10, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL en_resume: gnt=%h idx=%0d vld=%b, want 10 4 1",
                     bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
    endtask

    task automatic test_back_to_back();
        // done together with withdrawal is a single release: 4 -> 5, not 4 -> 5 -> 6
        bus.req  = 8'h60;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tests++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h20, 3'd5}) begin
            fails++;
            $display("FAIL done_withdraw: gnt=%h idx=%0d, want 20 5", bus.gnt, bus.gnt_idx);
        end
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h20, 3'd5}) begin
            fails++;
            $display("FAIL single_release: gnt=%h idx=%0d, want 20 5", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_idle_done();
        bus.req = 8'h00;
        tick();
        bus.done = 1'b1;
        tick();
        tick();
        bus.done = 1'b0;
        tests++;
        if (bus.gnt_vld !== 1'b0) begin
            fails++;
            $display("FAIL idle_done_vld: vld=%b, want 0", bus.gnt_vld);
        end
        // ptr must still be 6 after the idle done pulses
        bus.req = 8'h41;
        tick();
        tests++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h40, 3'd6}) begin
            fails++;
            $display("FAIL idle_done_ptr: gnt=%h idx=%0d, want 40 6", bus.gnt, bus.gnt_idx);
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early   = 0;
        bus.req = 8'h01;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (bus.to_pls !== 1'b0 || bus.gnt !== 8'h01) early++;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL timeout_hold: %0d bad cycles in first 16, want 0", early);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        tests++;
        if ({bus.to_pls, bus.gnt, bus.gnt_idx, bus.gnt_vld} !== {1'b1, 8'h01, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL timeout_pulse: to=%b gnt=%h idx=%0d vld=%b, want 1 01 0 1",
                     bus.to_pls, bus.gnt, bus.gnt_idx, bus.gnt_vld);
        end
        tick();
        tests++;
        if (bus.to_pls !== 1'b0 || bus.gnt !== 8'h01) begin
            fails++;
            $display("FAIL timeout_width: to=%b gnt=%h, want 0 01", bus.to_pls, bus.gnt);
        end
`else
        tests++;
        if (bus.to_pls !== 1'b0 || bus.gnt !== 8'h01 || bus.gnt_vld !== 1'b1) begin
            fails++;
            $display("FAIL no_timeout: to=%b gnt=%h vld=%b, want 0 01 1",
                     bus.to_pls, bus.gnt, bus.gnt_vld);
        end
`endif
        bus.req = 8'h00;
        tick();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        #12;
        test_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_single();
        test_reset_mid_grant();
        test_rotation();
        test_wrap();
        test_withdraw_enable();
        test_back_to_back();
        test_idle_done();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
